// File: rtl/behavioral_brom_stream.sv
// Burst-read streamer over a small behavioural ROM.
// A request (start address, beat count - 1) is accepted in IDLE. The BURST state
// then issues one synchronous ROM read per cycle, as long as fewer than four beats
// are outstanding. A beat is outstanding while its read is in flight or while it
// waits in the output FIFO. Read data passes through the ROM output register into
// a 4-entry FIFO. That FIFO drives the valid/ready response port.
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready is high
//   BURST | issuing reads for the accepted burst until the final beat issues
module behavioral_brom_stream #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 1024,
    parameter  int LEN_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Credit limit: in-flight reads plus FIFO entries never exceed the FIFO depth,
    // so a push can never find the FIFO full.
    localparam logic [2:0] MAX_OUTST = 3'd4;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         outst_q, outst_d;

    logic               issue;
    logic               issue_last;
    logic               pop;
    logic               push;

    logic               rd_vld_q;
    logic               rd_last_q;
    logic [WIDTH-1:0]   rd_data_q;

    logic [WIDTH-1:0]   fifo_data_q [4];
    logic               fifo_last_q [4];
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]         fifo_cnt_q, fifo_cnt_d;

    // Fixed ROM image. The first eight words are 16-bit constants and every other
    // address reads as zero. Words are resized to WIDTH by truncation or zero-extension.
    function automatic logic [WIDTH-1:0] rom_word(input logic [AW-1:0] a);
        logic [15:0] w16;
        logic [63:0] w64;
        w16 = 16'h0000;
        if ((a >> 3) == '0) begin
            case (a[2:0])
                3'd0: w16 = 16'hC1A1;
                3'd1: w16 = 16'hA2B2;
                3'd2: w16 = 16'hDAC3;
                3'd3: w16 = 16'hFCD4;
                3'd4: w16 = 16'h12E5;
                3'd5: w16 = 16'h03F6;
                3'd6: w16 = 16'h2117;
                3'd7: w16 = 16'h4428;
            endcase
        end
        w64 = {48'h0, w16};
        return w64[WIDTH-1:0];
    endfunction

    // Handshake and issue qualifiers
    always_comb begin
        req_ready  = (state_q == IDLE) && !reset;
        issue      = (state_q == BURST) && (outst_q < MAX_OUTST);
        issue_last = issue && (cnt_q == '0);
        push       = rd_vld_q;
        pop        = rsp_valid && rsp_ready;
    end

    // Next-state logic: accept in IDLE, walk the address and count down in BURST
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    // DEPTH is a power of two, so the natural overflow wraps to 0
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (issue_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-beat and FIFO bookkeeping
    always_comb begin
        outst_d    = outst_q + {2'b00, issue} - {2'b00, pop};
        fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
        wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    end

    // Control registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            outst_q    <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            outst_q    <= outst_d;
            rd_vld_q   <= issue;
            rd_last_q  <= issue_last;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Synchronous ROM read with enable; left unreset so it maps onto block memory
    always_ff @(posedge clock) begin
        if (issue) begin
            rd_data_q <= rom_word(addr_q);
        end
    end

    // FIFO storage; occupancy is tracked by the reset-controlled counters above
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rd_data_q;
            fifo_last_q[wr_ptr_q] <= rd_last_q;
        end
    end

    // Response port; data and last are forced to zero while no beat is presented
    always_comb begin
        rsp_valid = (fifo_cnt_q != '0);
        rsp_data  = '0;
        rsp_last  = 1'b0;
        if (rsp_valid) begin
            rsp_data = fifo_data_q[rd_ptr_q];
            rsp_last = fifo_last_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_behavioral_brom_stream.sv
// Directed bench: a 16-bit/1024-word instance covers the burst, wrap, backpressure
// and reset cases, and an 8-bit/16-word instance covers the resized ROM image.
module tb_behavioral_brom_stream;

    logic        clock = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_last;
    logic [9:0]  req_addr;
    logic [7:0]  req_len;
    logic [15:0] rsp_data;

    logic        req8_valid, req8_ready, rsp8_valid, rsp8_ready, rsp8_last;
    logic [3:0]  req8_addr;
    logic [3:0]  req8_len;
    logic [7:0]  rsp8_data;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [15:0] exp_data [8];
    logic        exp_last [8];

    always #5 clock = ~clock;

    behavioral_brom_stream #(.WIDTH(16), .DEPTH(1024), .LEN_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last)
    );

    behavioral_brom_stream #(.WIDTH(8), .DEPTH(16), .LEN_W(4)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req8_valid),
        .req_ready (req8_ready),
        .req_addr  (req8_addr),
        .req_len   (req8_len),
        .rsp_valid (rsp8_valid),
        .rsp_ready (rsp8_ready),
        .rsp_data  (rsp8_data),
        .rsp_last  (rsp8_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request, hold it until accepted, then scramble the request fields.
    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic do_req(input logic [9:0] a, input logic [7:0] l);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        while (!req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("req_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = 10'h2AA;
        req_len   = 8'h55;
    endtask

    // Gather n beats against exp_data/exp_last; strict demands back-to-back beats
    task automatic collect(input int n, input bit strict, input string tag);
        int got;
        int w;
        got = 0;
        w   = 0;
        while (got < n && w < 60) begin
            if (strict && got > 0) chk({tag, "_stream"}, rsp_valid, 1);
            if (rsp_valid && rsp_ready) begin
                chk({tag, "_data"}, rsp_data, exp_data[got]);
                chk({tag, "_last"}, rsp_last, exp_last[got]);
                got++;
            end
            @(negedge clock);
            w++;
        end
        chk({tag, "_count"}, got, n);
        chk({tag, "_drained"}, rsp_valid, 0);
    endtask

    initial begin
        int cnt8;
        int last_at;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        rsp_ready  = 1'b1;
        req8_valid = 1'b0;
        req8_addr  = '0;
        req8_len   = '0;
        rsp8_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_rsp_last",  rsp_last, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", req_ready, 1);

        // Single beat: first valid exactly three cycles after acceptance
        req_valid = 1'b1;
        req_addr  = 10'd3;
        req_len   = 8'd0;
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = 10'h3FF;
        req_len   = 8'hFF;
        chk("single_k1_valid", rsp_valid, 0);
        @(negedge clock);
        chk("single_k2_valid", rsp_valid, 0);
        @(negedge clock);
        chk("single_k3_valid", rsp_valid, 1);
        chk("single_k3_data",  rsp_data, 16'hFCD4);
        chk("single_k3_last",  rsp_last, 1);
        @(negedge clock);
        chk("single_k4_valid", rsp_valid, 0);
        chk("single_k4_data",  rsp_data, 0);
        chk("single_k4_last",  rsp_last, 0);

        // Burst running past the populated words
        exp_data = '{16'h2117, 16'h4428, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_req(10'd6, 8'd3);
        collect(4, 1'b1, "a6");

        // Wrap from the top of the address space
        exp_data = '{16'h0000, 16'h0000, 16'hC1A1, 16'hA2B2, 16'h0, 16'h0, 16'h0, 16'h0};
        do_req(10'd1022, 8'd3);
        collect(4, 1'b1, "wrap");

        // Backpressure: ten stalled cycles after acceptance, then drain
        rsp_ready = 1'b0;
        do_req(10'd0, 8'd7);
        for (int i = 1; i <= 10; i++) begin
            chk("hold_outst_le4", dut.outst_q <= 3'd4, 1);
            if (i >= 3) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data",  rsp_data, 16'hC1A1);
                chk("hold_last",  rsp_last, 0);
            end
            if (i == 10) chk("hold_outst_full", dut.outst_q, 4);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        exp_data = '{16'hC1A1, 16'hA2B2, 16'hDAC3, 16'hFCD4,
                     16'h12E5, 16'h03F6, 16'h2117, 16'h4428};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        collect(8, 1'b1, "hold");

        // Second request accepted while the first burst drains
        exp_data = '{16'hDAC3, 16'hFCD4, 16'h03F6, 16'h2117, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        fork
            collect(4, 1'b0, "b2b");
            begin
                do_req(10'd2, 8'd1);
                do_req(10'd5, 8'd1);
            end
        join

        // Reset in the third beat discards the rest of the burst
        do_req(10'd0, 8'd7);
        @(negedge clock);
        @(negedge clock);
        chk("mid_b0_data", rsp_data, 16'hC1A1);
        @(negedge clock);
        chk("mid_b1_data", rsp_data, 16'hA2B2);
        @(negedge clock);
        chk("mid_b2_valid", rsp_valid, 1);
        chk("mid_b2_data",  rsp_data, 16'hDAC3);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data",  rsp_data, 0);
        chk("mid_rst_ready", req_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_post_ready", req_ready, 1);
        chk("mid_post_valid", rsp_valid, 0);
        exp_data = '{16'h12E5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_last = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_req(10'd4, 8'd0);
        collect(1, 1'b1, "after_rst");

        // Narrow, shallow instance
        req8_valid = 1'b1;
        req8_addr  = 4'd2;
        req8_len   = 4'd0;
        @(negedge clock);
        req8_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("w8_a2_valid", rsp8_valid, 1);
        chk("w8_a2_data",  rsp8_data, 8'hC3);
        chk("w8_a2_last",  rsp8_last, 1);
        @(negedge clock);
        req8_valid = 1'b1;
        req8_addr  = 4'd15;
        req8_len   = 4'd1;
        @(negedge clock);
        req8_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("w8_a15_b0_valid", rsp8_valid, 1);
        chk("w8_a15_b0_data",  rsp8_data, 8'h00);
        chk("w8_a15_b0_last",  rsp8_last, 0);
        @(negedge clock);
        chk("w8_a15_b1_valid", rsp8_valid, 1);
        chk("w8_a15_b1_data",  rsp8_data, 8'hA1);
        chk("w8_a15_b1_last",  rsp8_last, 1);
        @(negedge clock);

        // Maximum length on the 4-bit length field: 16 beats, last on the 16th
        req8_valid = 1'b1;
        req8_addr  = 4'd8;
        req8_len   = 4'd15;
        @(negedge clock);
        req8_valid = 1'b0;
        cnt8    = 0;
        last_at = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp8_valid) begin
                cnt8++;
                if (cnt8 == 9) chk("w8_max_wrap_data", rsp8_data, 8'hA1);
                if (rsp8_last) last_at = cnt8;
            end
            @(negedge clock);
        end
        chk("w8_max_count",   cnt8, 16);
        chk("w8_max_last_at", last_at, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
